// File: rtl/compare_arbiter_pkg.sv
// Shared definitions for the compare arbiter: requester count, operand
// width, id width and the FSM state encoding.
package compare_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int W    = 3;
  localparam int IDW  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  // Round-robin successor; the two-bit width makes 3 wrap to 0.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return id + 2'd1;
  endfunction

endpackage

// File: rtl/compare_arbiter_comparator.sv
// Three-bit magnitude comparator shared by all requesters of the arbiter.
module comparator_3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       eq,
  output logic       lt,
  output logic       gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter that lets four requesters share one comparator.
// One transaction in flight: grant in IDLE, compare, then hold the
// result in RESPOND until downstream accepts it.
module compare_arbiter #(
  parameter int NREQ = compare_arbiter_pkg::NREQ,
  parameter int W    = compare_arbiter_pkg::W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic              rsp_eq,
  output logic              rsp_lt,
  output logic              rsp_gt,
  output logic              busy,
  output logic [7:0]        cmp_count
);

  import compare_arbiter_pkg::*;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic           eq_q, eq_d;
  logic           lt_q, lt_d;
  logic           gt_q, gt_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [NREQ-1:0] rot_valid;
  logic [IDW-1:0]  grant_ofs;
  logic [IDW-1:0]  grant_idx;
  logic            grant_found;
  logic [NREQ-1:0] req_ready_c;
  logic            cmp_eq, cmp_lt, cmp_gt;

  // Rotate the request vector so that position 0 is the requester at rr_ptr.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      assign rot_valid[gi] = req_valid[rr_ptr_q + 2'(gi)];
    end
  endgenerate

  // Pick the lowest rotated position, i.e. the first valid at or after rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_ofs   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_found = 1'b1;
        grant_ofs   = 2'(k);
      end
    end
  end

  assign grant_idx = rr_ptr_q + grant_ofs;

  // The comparator always looks at the captured operands of the owner.
  comparator_3bit u_cmp (
    .a  (op_a_q),
    .b  (op_b_q),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  // Next-state and grant logic; req_ready can only rise in IDLE.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    gt_d        = gt_q;
    cnt_d       = cnt_q;
    req_ready_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          op_a_d  = req_a[grant_idx*W +: W];
          op_b_d  = req_b[grant_idx*W +: W];
          id_d    = grant_idx;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        eq_d    = cmp_eq;
        lt_d    = cmp_lt;
        gt_d    = cmp_gt;
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          rr_ptr_d = next_id(id_q);
          cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready = req_ready_c;
  assign rsp_valid = (state_q == ST_RESPOND);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_id    = id_q;
  // Stale flags are masked so all three read 0 outside RESPOND.
  assign rsp_eq    = eq_q & rsp_valid;
  assign rsp_lt    = lt_q & rsp_valid;
  assign rsp_gt    = gt_q & rsp_valid;
  assign cmp_count = cnt_q;

endmodule
